// File: rtl/digit_confirm_pkg.sv
// Shared types and constants for the digit confirm/display stage.
// Combinational constants only; no latency.
// No flow control.
package digit_confirm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int unsigned NUM_CLASSES = 10;

    // Segment patterns are {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/digit_confirm_display_seg7_decode.sv
// Digit to active-high 7-segment pattern; codes above 9 decode to blank.
// Purely combinational, zero latency.
// No flow control.
module seg7_decode
    import digit_confirm_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_confirm_display.sv
// Debounces classifier codes into a committed 7-seg digit with hold timeout; SEG_ACTIVE_LOW_EN inverts seg_out.
// Latency: commit visible one cycle after the STABLE_COUNT-th matching accepted sample.
// Backpressure: class_ready drops for the single COMMIT cycle and whenever ena=0.
module digit_confirm_display
    import digit_confirm_pkg::*;
#(
    parameter int unsigned STABLE_COUNT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       class_valid,
    input  logic [3:0] class_in,
    output logic       class_ready,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       new_digit,
    output logic [6:0] seg_out,
    output logic [7:0] reject_cnt
);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_OFF = ~SEG_BLANK;
`else
    localparam logic [6:0] SEG_OFF = SEG_BLANK;
`endif

    state_t          state;
    state_t          nxt_state;
    logic [3:0]      candidate;
    logic [3:0]      nxt_cand;
    logic [3:0]      count;
    logic [3:0]      nxt_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            accept;
    logic            is_digit;
    logic            commit;
    logic            match;
    logic            expire;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_drive;

    seg7_decode u_dec (
        .digit (class_in),
        .seg   (dec_seg)
    );

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_drive = ~dec_seg;
`else
    assign seg_drive = dec_seg;
`endif

    assign class_ready = ena & (state != COMMIT);
    assign accept      = class_valid & class_ready;
    assign is_digit    = (class_in < 4'(NUM_CLASSES));
    assign match       = accept & is_digit & digit_valid & (class_in == digit_out);
    // The expiry edge fires even if a matching sample lands on it.
    assign expire      = digit_valid & (TIMEOUT_CYCLES != 0) &
                         (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        nxt_state = state;
        nxt_cand  = candidate;
        nxt_cnt   = count;
        commit    = 1'b0;
        if (state == COMMIT) begin
            nxt_state = HOLD;
        end else if (accept) begin
            if (!is_digit) begin
                if (state == TRACK) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            end else if (state == TRACK && class_in == candidate) begin
                nxt_cnt = count + 4'd1;
                commit  = ((count + 4'd1) == 4'(STABLE_COUNT));
            end else if (!(state == HOLD && class_in == digit_out)) begin
                nxt_cand  = class_in;
                nxt_cnt   = 4'd1;
                nxt_state = TRACK;
                commit    = (STABLE_COUNT == 1);
            end
            if (commit) begin
                nxt_state = COMMIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            candidate   <= '0;
            count       <= '0;
            to_cnt      <= '0;
            digit_out   <= '0;
            digit_valid <= 1'b0;
            new_digit   <= 1'b0;
            seg_out     <= SEG_OFF;
            reject_cnt  <= '0;
        end else if (ena) begin
            candidate <= nxt_cand;
            count     <= nxt_cnt;
            new_digit <= commit;
            if (accept && !is_digit && reject_cnt != 8'hFF) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
            // Commit beats an expiry landing on the same edge.
            if (commit) begin
                state       <= COMMIT;
                digit_out   <= class_in;
                digit_valid <= 1'b1;
                seg_out     <= seg_drive;
                to_cnt      <= '0;
            end else if (expire) begin
                digit_valid <= 1'b0;
                seg_out     <= SEG_OFF;
                to_cnt      <= '0;
                state       <= (state == HOLD) ? IDLE : nxt_state;
            end else begin
                state <= nxt_state;
                if (match) begin
                    to_cnt <= '0;
                end else if (digit_valid && TIMEOUT_CYCLES != 0) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_confirm_display.sv
// Scoreboarded bench: a run-length reference model predicts every cycle's outputs into a queue;
// a monitor pops and compares on each falling edge.
module tb_digit_confirm_display;

    localparam int STABLE = 4;
    localparam int TMO    = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       class_valid;
    logic [3:0] class_in;
    logic       class_ready;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       new_digit;
    logic [6:0] seg_out;
    logic [7:0] reject_cnt;

    always #5 clk = ~clk;

    digit_confirm_display #(
        .STABLE_COUNT   (STABLE),
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .class_valid (class_valid),
        .class_in    (class_in),
        .class_ready (class_ready),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .new_digit   (new_digit),
        .seg_out     (seg_out),
        .reject_cnt  (reject_cnt)
    );

    typedef struct packed {
        logic       cr;
        logic [3:0] dig;
        logic       dv;
        logic       nd;
        logic [6:0] seg;
        logic [7:0] rej;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    int seg_tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    // Reference model: run of identical digits, whether a digit is shown and held, idle timer.
    bit m_pulse, m_hold, m_shown_v;
    int m_run_d, m_run_len, m_shown, m_timer, m_rej;

    task automatic model_step();
        bit acc, commit_now, expire_now, hold_pre, matched;
        int d;
        if (!rst_n) begin
            m_pulse = 0; m_hold = 0; m_shown_v = 0;
            m_run_d = 0; m_run_len = 0; m_shown = 0; m_timer = 0; m_rej = 0;
            return;
        end
        if (!ena) return;
        d          = int'(class_in);
        acc        = class_valid && !m_pulse;
        hold_pre   = m_hold;
        expire_now = m_shown_v && (TMO != 0) && (m_timer == TMO);
        matched    = acc && d < 10 && m_shown_v && d == m_shown;
        commit_now = 0;
        if (m_pulse) begin
            m_hold = 1;
        end else if (acc) begin
            if (d >= 10) begin
                if (m_rej < 255) m_rej++;
                if (!m_hold) m_run_len = 0;
            end else if (!(m_hold && d == m_shown)) begin
                if (!m_hold && m_run_len > 0 && d == m_run_d) m_run_len++;
                else begin
                    m_run_d   = d;
                    m_run_len = 1;
                end
                m_hold     = 0;
                commit_now = (m_run_len == STABLE);
            end
        end
        if (commit_now) begin
            m_shown = d; m_shown_v = 1; m_timer = 0;
        end else if (expire_now) begin
            m_shown_v = 0; m_timer = 0;
            if (hold_pre) begin
                m_hold = 0; m_run_len = 0;
            end
        end else if (matched) begin
            m_timer = 0;
        end else if (m_shown_v) begin
            m_timer++;
        end
        m_pulse = commit_now;
    endtask

    function automatic logic [6:0] model_seg();
        logic [6:0] s;
        s = m_shown_v ? 7'(seg_tbl[m_shown]) : 7'h00;
`ifdef SEG_ACTIVE_LOW_EN
        s = ~s;
`endif
        return s;
    endfunction

    // One clock: apply the edge to the model, drive new inputs, predict the outputs.
    task automatic cyc(input logic r, input logic e, input logic v, input logic [3:0] d);
        exp_t x;
        @(posedge clk);
        #1;
        model_step();
        rst_n       = r;
        ena         = e;
        class_valid = v;
        class_in    = d;
        x.cr  = e && !m_pulse;
        x.dig = 4'(m_shown);
        x.dv  = m_shown_v;
        x.nd  = m_pulse;
        x.seg = model_seg();
        x.rej = 8'(m_rej);
        q.push_back(x);
        cyc_no++;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (class_ready !== x.cr || digit_out !== x.dig || digit_valid !== x.dv ||
                    new_digit !== x.nd || seg_out !== x.seg || reject_cnt !== x.rej) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got rdy=%b dig=%0d dv=%b nd=%b seg=%h rej=%0d, want rdy=%b dig=%0d dv=%b nd=%b seg=%h rej=%0d",
                             cyc_no, class_ready, digit_out, digit_valid, new_digit, seg_out, reject_cnt,
                             x.cr, x.dig, x.dv, x.nd, x.seg, x.rej);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] last;
        int         quiet;
        rst_n = 1'b0; ena = 1'b0; class_valid = 1'b0; class_in = 4'd0;
        last = 4'd0; quiet = 0;

        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 3);
        repeat (3) cyc(1, 1, 0, 0);
        foreach (seg_tbl[i]) begin end
        begin
            logic [3:0] seq [7] = '{4'd7, 4'd7, 4'd2, 4'd7, 4'd7, 4'd7, 4'd7};
            foreach (seq[i]) cyc(1, 1, 1, seq[i]);
        end
        repeat (2) cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 8);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 1, 12);
        repeat (3) cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 1);
        repeat (16) cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 1);
        repeat (5) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 1);
        repeat (16) cyc(1, 1, 0, 0);
        repeat (2) cyc(1, 1, 1, 4);
        cyc(0, 1, 1, 4);
        repeat (3) cyc(1, 1, 1, 4);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 4);
        repeat (2) cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 0);
        repeat (3) cyc(1, 0, 1, 5);
        repeat (3) cyc(1, 1, 0, 0);
        repeat (270) cyc(1, 1, 1, 12);

        for (int i = 0; i < 3000; i++) begin
            logic       r, e, v;
            logic [3:0] d;
            int         p;
            p = int'($urandom_range(99));
            r = ($urandom_range(499) != 0);
            e = ($urandom_range(9) != 0);
            v = ($urandom_range(9) < 7);
            if (quiet > 0) begin
                v = 1'b0;
                quiet--;
            end else if ($urandom_range(99) < 3) begin
                quiet = int'($urandom_range(20, 8));
            end
            if (p < 55)      d = last;
            else if (p < 85) d = 4'($urandom_range(9));
            else             d = 4'($urandom_range(15, 10));
            if (d < 4'd10) last = d;
            cyc(r, e, v, d);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_confirm_display.md
Name: digit_confirm_display

Overview:
- Downstream stage of the perceptron digit classifier.
- Samples the 4-bit class code via a valid/ready handshake and rejects codes 10–15 (no-match).
- Commits a digit only after STABLE_COUNT consecutive identical accepted samples.
- Holds the committed digit on a 7-segment output until a different digit is confirmed or the timeout expires.

Parameters:
- STABLE_COUNT, 4: consecutive identical valid samples required to commit; legal range 1–15.
- TIMEOUT_CYCLES, 255: enabled cycles without a sample matching the committed digit before the display blanks; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  block enable; when 0, all registers hold and class_ready=0
- class_valid  input  1  class_in is valid this cycle
- class_in  input  4  perceptron class code; 0–9 is a digit, 10–15 is no-match
- class_ready  output  1  sample accepted when class_valid & class_ready at the rising edge
- digit_out  output  4  committed digit
- digit_valid  output  1  digit_out/seg_out show a committed digit
- new_digit  output  1  one-cycle pulse after each commit
- seg_out  output  7  {g,f,e,d,c,b,a}, active high
- reject_cnt  output  8  saturating count of accepted no-match codes

Behaviour:
- Reset: all outputs are registered. The edge with rst_n=0 clears the state to IDLE and sets digit_out=0, digit_valid=0, new_digit=0, seg_out=0x00, reject_cnt=0, candidate=0, match count=0 and timeout counter=0, regardless of ena. Reset mid-track discards the candidate.
- class_ready = ena & (state != COMMIT). This is combinational from registered state.
- FSM states:
  - IDLE: accepted digit d → candidate=d, count=1, go to TRACK; if STABLE_COUNT=1, go straight to COMMIT. Accepted no-match → reject_cnt+1, stay in IDLE.
  - TRACK, accepted d == candidate: count+1. If the count reaches STABLE_COUNT, go to COMMIT.
  - TRACK, accepted digit != candidate: candidate=d, count=1, stay in TRACK.
  - TRACK, accepted no-match: reject_cnt+1, count=0, go to IDLE. The committed digit is retained.
  - Commit update: on the edge that enters COMMIT, digit_out=candidate, digit_valid=1, seg_out=decode(candidate), timeout counter=0.
  - COMMIT: lasts exactly one cycle with new_digit=1 and class_ready=0, then goes to HOLD.
  - HOLD, accepted d == digit_out: timeout counter cleared, stay in HOLD.
  - HOLD, accepted d != digit_out: candidate=d, count=1, go to TRACK. The display keeps the old digit.
  - HOLD, accepted no-match: reject_cnt+1, stay in HOLD.
- Re-committing the same digit in TRACK, e.g. 5,6,5,5,5,5: commit occurs, new_digit pulses, digit_out is unchanged.
- Latency: the commit is visible on outputs in the cycle after the STABLE_COUNT-th accepted sample.
- Timeout:
  - When digit_valid=1, ena=1 and no sample matching digit_out is accepted in a cycle, the timeout counter increments.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), the next edge sets digit_valid=0, seg_out=0x00 and clears the counter.
  - If state was HOLD, it goes to IDLE; TRACK continues unaffected.
  - A timeout and a commit on the same edge: the commit wins.
- reject_cnt saturates at 255.
- ena=0: everything holds, including the timeout count. A class_valid asserted while ena=0 is ignored.
- Seg decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, active high).

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: seg_out is bitwise inverted for common-anode displays. Reset and blank value becomes 0x7F; all decode values are inverted.
- Undefined: active-high encoding as above. No other behaviour changes.

Decomposition:
- Package digit_confirm_pkg holds:
  - state enum {IDLE, TRACK, COMMIT, HOLD}
  - NUM_CLASSES=10
  - SEG_BLANK
  - the ten-entry segment table constants
- One combinational sub-module, seg7_decode: 4-bit digit in, 7-bit pattern out, blank for inputs above 9.
- The output inversion for SEG_ACTIVE_LOW_EN is applied in the parent.

Test Plan:
- Reset with rst_n=0 for 2 cycles → digit_valid=0, seg_out=0x00, reject_cnt=0, class_ready=1 after release with ena=1.
- Four consecutive accepted 3s → next cycle digit_out=3, seg_out=0x4F, new_digit=1 for one cycle, class_ready=0 that cycle.
- Sequence 7,7,2,7,7,7,7 → no commit until the 4th trailing 7; no new_digit pulse before then.
- Committed 8, then class_in=12 accepted three times → reject_cnt=3, digit_out stays 8, state HOLD.
- Committed 1, TIMEOUT_CYCLES=10, no samples → digit_valid drops 11 cycles after the commit edge, seg_out=0x00; a matching 1 sampled at cycle 5 restarts the count.
- Mid-TRACK, assert rst_n=0 for one edge → candidate cleared; three further 4s do not commit, a fourth does. Repeat with SEG_ACTIVE_LOW_EN: reset seg_out=0x7F, a committed 0 gives seg_out=0x40.
